// File: rtl/iconn_merge_node.sv
// Two-port merge node: per-port FIFOs feeding one registered valid/ready output.
// The smallest destination address wins. Define ICONN_MERGE_AGING_EN for starvation aging.
module iconn_merge_node #(
  parameter int PORT_NUM        = 2,
  parameter int NODE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int AGE_LIMIT       = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      in_data  [0:PORT_NUM-1],
  input  logic [NODE_ADDR_WIDTH-1:0] in_addr  [0:PORT_NUM-1],
  input  logic [PORT_NUM-1:0]        in_valid,
  output logic [PORT_NUM-1:0]        in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [NODE_ADDR_WIDTH-1:0] out_addr,
  output logic                       out_port,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [PORT_NUM-1:0]        push;
  logic [PORT_NUM-1:0]        pop;
  logic [PORT_NUM-1:0]        hv;
  logic [PORT_NUM-1:0]        full;
  logic [DATA_WIDTH-1:0]      head_data [0:PORT_NUM-1];
  logic [NODE_ADDR_WIDTH-1:0] head_addr [0:PORT_NUM-1];
  logic                       sel_addr;
  logic                       sel;
  logic                       load;

  assign push     = in_valid & ~full;
  assign in_ready = ~full;
  assign load     = (|hv) && (!out_valid || out_ready);

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_fifo
    logic [DATA_WIDTH-1:0]      mem_data [0:FIFO_DEPTH-1];
    logic [NODE_ADDR_WIDTH-1:0] mem_addr [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    assign pop[p]       = load && (sel == 1'(p));
    assign full[p]      = (count == DEPTH_CNT);
    assign hv[p]        = (count != '0);
    assign head_data[p] = mem_data[rd_ptr];
    assign head_addr[p] = mem_addr[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[p]) begin
        mem_data[wr_ptr] <= in_data[p];
        mem_addr[wr_ptr] <= in_addr[p];
      end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[p]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[p])  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[p], pop[p]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Equal addresses resolve to port 1.
  assign sel_addr = !hv[0] ? 1'b1 :
                    !hv[1] ? 1'b0 :
                    (head_addr[0] < head_addr[1]) ? 1'b0 : 1'b1;

`ifdef ICONN_MERGE_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [PORT_NUM-1:0] aged;

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_age
    logic [AGE_W-1:0] age;

    assign aged[p] = hv[p] && (age == AGE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age <= '0;
      end else if (load) begin
        if (sel == 1'(p))
          age <= '0;
        else if (hv[p] && (age != AGE_MAX))
          age <= age + AGE_W'(1);
      end
    end
  end

  // A starved port overrides the address rule; port 0 wins if both are starved.
  assign sel = aged[0] ? 1'b0 : aged[1] ? 1'b1 : sel_addr;
`else
  localparam int unused_age_limit = AGE_LIMIT;

  assign sel = sel_addr;
`endif

  // Output register: load on a free slot, clear once the held flit is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_addr  <= '0;
      out_port  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= head_data[sel];
      out_addr  <= head_addr[sel];
      out_port  <= sel;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
